// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_cfg : configurable UART transmitter (5-9 data bits, none/odd/even |
// |               parity, 1-2 stop bits) with a one-word holding register.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_cfg #(
   parameter int CLK_PER_BIT = 87,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_dv_in,
   input  logic [DATA_BITS-1:0] tx_b,
   output logic                 tx_ready_out,
   output logic                 tx_active_out,
   output logic                 tx_serial_out,
   output logic                 tx_done_out
);

   localparam int c_CNT_W = (CLK_PER_BIT >= 2) ? $clog2(CLK_PER_BIT) : 1;
   localparam int c_IDX_W = $clog2(DATA_BITS) + 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLK_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
   localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
          STOP_BITS < 1 || STOP_BITS > 2 || CLK_PER_BIT < 2) begin : g_param_check
         $error("uart_tx_cfg: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   state_t                 r_state;
   logic [DATA_BITS-1:0]   r_hold;
   logic                   r_hold_full;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_parity;
   logic [c_CNT_W-1:0]     r_clk_cnt;
   logic [c_IDX_W-1:0]     r_idx;
   logic                   r_stop_cnt;

   logic                   w_bit_end;
   logic                   w_hold_par;
   logic                   w_line;
   logic                   w_done;

   assign w_bit_end    = (r_clk_cnt == c_CNT_LAST);
   assign w_hold_par   = (PARITY == 1) ? ~(^r_hold) : (^r_hold);
   assign w_done       = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == c_STOP_LAST);
   assign tx_ready_out = ~r_hold_full;

   // Line level for the current state; registered below, so the pin trails the FSM by one clock.
   always_comb begin
      w_line = 1'b1;
      case (r_state)
         S_START: w_line = 1'b0;
         S_DATA:  w_line = r_shift[0];
         S_PAR:   w_line = r_parity;
         default: w_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_hold        <= '0;
         r_hold_full   <= 1'b0;
         r_shift       <= '0;
         r_parity      <= 1'b0;
         r_clk_cnt     <= '0;
         r_idx         <= '0;
         r_stop_cnt    <= 1'b0;
         tx_serial_out <= 1'b1;
         tx_active_out <= 1'b0;
         tx_done_out   <= 1'b0;
      end else begin
         tx_serial_out <= w_line;
         tx_active_out <= (r_state != S_IDLE);
         tx_done_out   <= w_done;

         // Accept and reload are exclusive: accept needs an empty holding register, reload a full one.
         if (tx_dv_in && !r_hold_full) begin
            r_hold      <= tx_b;
            r_hold_full <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_clk_cnt <= '0;
               if (r_hold_full) begin
                  r_shift     <= r_hold;
                  r_parity    <= w_hold_par;
                  r_hold_full <= 1'b0;
                  r_state     <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_idx     <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_shift   <= r_shift >> 1;
                  if (r_idx == c_IDX_LAST) begin
                     r_stop_cnt <= 1'b0;
                     r_state    <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     r_idx <= r_idx + c_IDX_ONE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
               end
            end

            S_PAR: begin
               if (w_bit_end) begin
                  r_clk_cnt  <= '0;
                  r_stop_cnt <= 1'b0;
                  r_state    <= S_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_stop_cnt == c_STOP_LAST) begin
                     // A waiting word goes straight into the next start bit, no idle gap.
                     if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_parity    <= w_hold_par;
                        r_hold_full <= 1'b0;
                        r_state     <= S_START;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
               end
            end

            default: begin
               r_clk_cnt <= '0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_cfg : frame-level bench for uart_tx_cfg across five configs.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_tx_cfg;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   dv;
   logic [8:0]     din [N];
   wire  [N-1:0]   rdy, act, ser, done;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [15:0] bits;
      int          len;
      int          k;
   } frame_t;

   frame_t sb_q [$];

   logic cap_ser [2048];
   logic cap_done[2048];
   logic cap_act [2048];
   logic cap_rdy [2048];
   logic exp_ser [2048];
   logic exp_done[2048];
   logic exp_act [2048];

   always #5 clk = ~clk;

   // 0: 8N1/87  1: 7E2/5  2: 8O1/4  3: 9N1/3  4: 8N1/2
   uart_tx_cfg #(.CLK_PER_BIT(87), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .tx_dv_in(dv[0]), .tx_b(din[0][7:0]),
      .tx_ready_out(rdy[0]), .tx_active_out(act[0]), .tx_serial_out(ser[0]), .tx_done_out(done[0]));
   uart_tx_cfg #(.CLK_PER_BIT(5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
      .clk(clk), .rst_n(rst_n), .tx_dv_in(dv[1]), .tx_b(din[1][6:0]),
      .tx_ready_out(rdy[1]), .tx_active_out(act[1]), .tx_serial_out(ser[1]), .tx_done_out(done[1]));
   uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .tx_dv_in(dv[2]), .tx_b(din[2][7:0]),
      .tx_ready_out(rdy[2]), .tx_active_out(act[2]), .tx_serial_out(ser[2]), .tx_done_out(done[2]));
   uart_tx_cfg #(.CLK_PER_BIT(3), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
      .clk(clk), .rst_n(rst_n), .tx_dv_in(dv[3]), .tx_b(din[3]),
      .tx_ready_out(rdy[3]), .tx_active_out(act[3]), .tx_serial_out(ser[3]), .tx_done_out(done[3]));
   uart_tx_cfg #(.CLK_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .tx_dv_in(dv[4]), .tx_b(din[4][7:0]),
      .tx_ready_out(rdy[4]), .tx_active_out(act[4]), .tx_serial_out(ser[4]), .tx_done_out(done[4]));

   function automatic int cpb_of(int k);
      case (k)
         0: return 87;
         1: return 5;
         2: return 4;
         3: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int nb_of(int k);
      case (k)
         1: return 7;
         3: return 9;
         default: return 8;
      endcase
   endfunction

   function automatic int par_of(int k);
      case (k)
         1: return 2;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int stp_of(int k);
      return (k == 1) ? 2 : 1;
   endfunction

   // Reference frame: start, data LSB first, optional parity, stop bits.
   function automatic frame_t make_frame(int k, logic [8:0] d);
      frame_t f;
      logic   p   = 1'b0;
      int     pos = 1;
      f.bits    = '1;
      f.k       = k;
      f.bits[0] = 1'b0;
      for (int i = 0; i < nb_of(k); i++) begin
         f.bits[pos] = d[i];
         p ^= d[i];
         pos++;
      end
      if (par_of(k) != 0) begin
         f.bits[pos] = (par_of(k) == 1) ? ~p : p;
         pos++;
      end
      f.len = pos + stp_of(k);
      return f;
   endfunction

   // Expand queued frames into a per-clock waveform, followed by one idle clock.
   function automatic int build_expected(int nframes);
      int j = 0;
      for (int f = 0; f < nframes; f++) begin
         if (sb_q.size() != 0) begin
            frame_t fr  = sb_q.pop_front();
            int     cpb = cpb_of(fr.k);
            for (int b = 0; b < fr.len; b++) begin
               for (int c = 0; c < cpb; c++) begin
                  exp_ser[j]  = fr.bits[b];
                  exp_act[j]  = 1'b1;
                  exp_done[j] = (b == fr.len - 1) && (c == cpb - 1);
                  j++;
               end
            end
         end
      end
      exp_ser[j]  = 1'b1;
      exp_act[j]  = 1'b0;
      exp_done[j] = 1'b0;
      return j + 1;
   endfunction

   function automatic int diff_count(int n, int which);
      int e = 0;
      for (int j = 0; j < n; j++) begin
         case (which)
            0: if (cap_ser[j]  !== exp_ser[j])  e++;
            1: if (cap_done[j] !== exp_done[j]) e++;
            default: if (cap_act[j] !== exp_act[j]) e++;
         endcase
      end
      return e;
   endfunction

   function automatic logic [15:0] decode(int cpb, int len);
      logic [15:0] v = '1;
      for (int i = 0; i < len; i++) v[i] = cap_ser[i*cpb + cpb/2];
      return v;
   endfunction

   // Called at a negedge; the word is accepted on the following posedge if ready.
   task automatic send(int k, logic [8:0] d);
      dv[k]  = 1'b1;
      din[k] = d;
      if (rdy[k] === 1'b1) sb_q.push_back(make_frame(k, d));
      @(negedge clk);
      dv[k] = 1'b0;
   endtask

   task automatic wait_fall(int k, int budget, output bit ok);
      int c = 0;
      while (ser[k] !== 1'b0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (ser[k] === 1'b0);
   endtask

   task automatic capture(int k, int n);
      for (int j = 0; j < n; j++) begin
         cap_ser[j]  = ser[k];
         cap_done[j] = done[k];
         cap_act[j]  = act[k];
         cap_rdy[j]  = rdy[k];
         if (j != n - 1) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bit          ok;
      int          n, e;
      logic        saw_done;
      logic        line_hi;
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({ser[k], act[k], rdy[k], done[k]} !== 4'b1010)
            $display("FAIL reset_state[%0d]: got ser/act/rdy/done=%b want 1010", k,
                     {ser[k], act[k], rdy[k], done[k]});
         else n_pass++;
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(0, 9'h0F0);
      wait_fall(0, 10, ok);
      n_checks++;
      if (!ok) $display("FAIL reset_pre_frame_start: got no start bit want start bit");
      else n_pass++;
      repeat (3*87) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ser[0], act[0], rdy[0], done[0]} !== 4'b1010)
         $display("FAIL reset_mid_frame: got ser/act/rdy/done=%b want 1010",
                  {ser[0], act[0], rdy[0], done[0]});
      else n_pass++;
      sb_q.delete();
      saw_done = 1'b0;
      line_hi  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         saw_done = saw_done | done[0];
         line_hi  = line_hi & ser[0];
      end
      n_checks++;
      if ({saw_done, line_hi} !== 2'b01)
         $display("FAIL reset_abandon: got done_seen/line_high=%b want 01", {saw_done, line_hi});
      else n_pass++;
      send(0, 9'h03C);
      wait_fall(0, 10, ok);
      n_checks++;
      if (!ok) $display("FAIL reset_post_start: got no start bit want start bit");
      else n_pass++;
      capture(0, 871);
      n = build_expected(1);
      e = diff_count(n, 0) + diff_count(n, 1) + diff_count(n, 2);
      n_checks++;
      if (e !== 0) $display("FAIL reset_post_frame: got %0d bad clocks want 0", e);
      else n_pass++;
   endtask

   task automatic test_8n1();
      int          n, e;
      logic [15:0] v;
      @(negedge clk);
      send(0, 9'h0A5);
      n_checks++;
      if ({rdy[0], ser[0]} !== 2'b01)
         $display("FAIL 8n1_accept: got rdy/ser=%b want 01", {rdy[0], ser[0]});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({rdy[0], ser[0], act[0]} !== 3'b110)
         $display("FAIL 8n1_load: got rdy/ser/act=%b want 110", {rdy[0], ser[0], act[0]});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({ser[0], act[0]} !== 2'b01)
         $display("FAIL 8n1_latency: got ser/act=%b want 01", {ser[0], act[0]});
      else n_pass++;
      capture(0, 871);
      v = decode(87, 10);
      n_checks++;
      if (v[9:0] !== 10'b1101001010)
         $display("FAIL 8n1_bits: got %b want 1101001010", v[9:0]);
      else n_pass++;
      n = build_expected(1);
      n_checks++;
      if (cap_done[869] !== 1'b1) $display("FAIL 8n1_done_pos: got %b want 1", cap_done[869]);
      else n_pass++;
      e = diff_count(n, 1);
      n_checks++;
      if (e !== 0) $display("FAIL 8n1_done_wave: got %0d bad clocks want 0", e);
      else n_pass++;
      e = diff_count(n, 0) + diff_count(n, 2);
      n_checks++;
      if (e !== 0) $display("FAIL 8n1_line_active: got %0d bad clocks want 0", e);
      else n_pass++;
   endtask

   task automatic test_7e2();
      bit          ok;
      int          n, e;
      logic [15:0] v;
      @(negedge clk);
      send(1, 9'h041);
      wait_fall(1, 10, ok);
      capture(1, 56);
      v = decode(5, 11);
      n_checks++;
      if (!ok || v[10:0] !== 11'b11010000010)
         $display("FAIL 7e2_bits: got %b want 11010000010", v[10:0]);
      else n_pass++;
      n = build_expected(1);
      e = diff_count(n, 0) + diff_count(n, 1) + diff_count(n, 2);
      n_checks++;
      if (e !== 0) $display("FAIL 7e2_wave: got %0d bad clocks want 0", e);
      else n_pass++;
   endtask

   task automatic test_parity();
      bit          ok;
      int          n, e;
      logic [15:0] v;
      logic [10:0] want [3];
      logic [8:0]  word [3];
      int          inst [3];
      want[0] = 11'b11000000000; word[0] = 9'h000; inst[0] = 2;
      want[1] = 11'b11111111110; word[1] = 9'h0FF; inst[1] = 2;
      want[2] = 11'b11111111110; word[2] = 9'h1FF; inst[2] = 3;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         send(inst[t], word[t]);
         wait_fall(inst[t], 10, ok);
         capture(inst[t], 11*cpb_of(inst[t]) + 1);
         v = decode(cpb_of(inst[t]), 11);
         n_checks++;
         if (!ok || v[10:0] !== want[t])
            $display("FAIL parity_bits[%0d]: got %b want %b", t, v[10:0], want[t]);
         else n_pass++;
         n = build_expected(1);
         e = diff_count(n, 0) + diff_count(n, 1) + diff_count(n, 2);
         n_checks++;
         if (e !== 0) $display("FAIL parity_wave[%0d]: got %0d bad clocks want 0", t, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      bit   ok;
      int   n, e, qs;
      logic line_hi;
      @(negedge clk);
      send(0, 9'h055);
      wait_fall(0, 10, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_start: got no start bit want start bit");
      else n_pass++;
      fork
         capture(0, 1741);
         begin
            repeat (100) @(negedge clk);
            send(0, 9'h0AA);
            n_checks++;
            if (rdy[0] !== 1'b0) $display("FAIL b2b_stall: got rdy=%b want 0", rdy[0]);
            else n_pass++;
            repeat (50) @(negedge clk);
            send(0, 9'h033);
         end
      join
      qs = sb_q.size();
      n_checks++;
      if (qs !== 2) $display("FAIL b2b_queued: got %0d frames want 2", qs);
      else n_pass++;
      n = build_expected(2);
      n_checks++;
      if ({cap_rdy[868], cap_rdy[869]} !== 2'b01)
         $display("FAIL b2b_reload_ready: got %b want 01", {cap_rdy[868], cap_rdy[869]});
      else n_pass++;
      e = diff_count(n, 0);
      n_checks++;
      if (e !== 0) $display("FAIL b2b_line: got %0d bad clocks want 0", e);
      else n_pass++;
      e = diff_count(n, 1) + diff_count(n, 2);
      n_checks++;
      if (e !== 0) $display("FAIL b2b_done_active: got %0d bad clocks want 0", e);
      else n_pass++;
      line_hi = 1'b1;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         line_hi = line_hi & ser[0] & ~act[0];
      end
      n_checks++;
      if ({line_hi, rdy[0]} !== 2'b11)
         $display("FAIL b2b_third_ignored: got idle/rdy=%b want 11", {line_hi, rdy[0]});
      else n_pass++;
   endtask

   task automatic test_fast_clk();
      bit ok;
      int n, e, qs;
      @(negedge clk);
      send(4, 9'h096);
      wait_fall(4, 10, ok);
      fork
         capture(4, 41);
         send(4, 9'h04B);
      join
      qs = sb_q.size();
      n_checks++;
      if (!ok || qs !== 2) $display("FAIL fast_queued: got %0d frames want 2", qs);
      else n_pass++;
      n = build_expected(2);
      e = diff_count(n, 0);
      n_checks++;
      if (e !== 0) $display("FAIL fast_line: got %0d bad clocks want 0", e);
      else n_pass++;
      e = diff_count(n, 1) + diff_count(n, 2);
      n_checks++;
      if (e !== 0) $display("FAIL fast_done_active: got %0d bad clocks want 0", e);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      dv    = '0;
      for (int k = 0; k < N; k++) din[k] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_8n1();
      test_7e2();
      test_parity();
      test_back_to_back();
      test_fast_clk();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
